// File: rtl/spi_bus_arbiter.sv
// Hands the SPI flash between the 6809 read controller and the FT2232-driven writer,
// halting the CPU and idling the bus for a guard period on every change of owner.
module spi_bus_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned GUARD_CYCLES  = 4,
    parameter int unsigned DRAIN_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_FT_CS,
    input  logic       i_cpu_spi_cs,
    input  logic       i_cpu_spi_clk,
    input  logic       i_cpu_spi_mosi,
    input  logic       i_wr_spi_cs,
    input  logic       i_wr_spi_clk,
    input  logic       i_wr_spi_mosi,
    output logic       o_SPI_CS,
    output logic       o_SPI_CLK,
    output logic       o_SPI_MOSI,
    output logic       o_HALT,
    output logic       o_cpu_grant,
    output logic       o_writer_grant,
    output logic       o_timeout,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        IDLE_CPU  = 3'd0,
        HALT_WAIT = 3'd1,
        GUARD_IN  = 3'd2,
        WRITER    = 3'd3,
        GUARD_OUT = 3'd4
    } state_t;

    localparam logic [7:0] LP_SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] LP_GUARD_LAST  = 8'(GUARD_CYCLES - 1);
    localparam logic [7:0] LP_DRAIN_LAST  = 8'(DRAIN_TIMEOUT - 1);

    state_t     r_state;
    state_t     w_nextState;
    logic [7:0] r_count;
    logic       r_ftSync1;
    logic       r_ftSync2;
    logic       w_ftReq;
    logic       w_setTimeout;

    assign w_ftReq = ~r_ftSync2;
    assign o_state = r_state;

    // Losing the request while still handing over always wins over any timed exit.
    always_comb begin
        w_nextState  = r_state;
        w_setTimeout = 1'b0;
        case (r_state)
            IDLE_CPU: begin
                if (w_ftReq) begin
                    w_nextState = HALT_WAIT;
                end
            end
            HALT_WAIT: begin
                if (!w_ftReq) begin
                    w_nextState = GUARD_OUT;
                end else if ((r_count >= LP_SETTLE_LAST) && i_cpu_spi_cs) begin
                    w_nextState = GUARD_IN;
                end else if (r_count == LP_DRAIN_LAST) begin
                    w_nextState  = GUARD_IN;
                    w_setTimeout = 1'b1;
                end
            end
            GUARD_IN: begin
                if (!w_ftReq) begin
                    w_nextState = GUARD_OUT;
                end else if (r_count == LP_GUARD_LAST) begin
                    w_nextState = WRITER;
                end
            end
            WRITER: begin
                if (!w_ftReq) begin
                    w_nextState = GUARD_OUT;
                end
            end
            GUARD_OUT: begin
                if (r_count == LP_GUARD_LAST) begin
                    w_nextState = IDLE_CPU;
                end
            end
            default: begin
                w_nextState = GUARD_OUT;
            end
        endcase
    end

    // Status outputs are decoded from the next state so they line up with o_state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= IDLE_CPU;
            r_count        <= 8'd0;
            r_ftSync1      <= 1'b1;
            r_ftSync2      <= 1'b1;
            o_HALT         <= 1'b1;
            o_cpu_grant    <= 1'b1;
            o_writer_grant <= 1'b0;
            o_timeout      <= 1'b0;
        end else begin
            r_state        <= w_nextState;
            r_count        <= (w_nextState != r_state) ? 8'd0 : r_count + 8'd1;
            r_ftSync1      <= i_FT_CS;
            r_ftSync2      <= r_ftSync1;
            o_HALT         <= (w_nextState == IDLE_CPU);
            o_cpu_grant    <= (w_nextState == IDLE_CPU) || (w_nextState == HALT_WAIT);
            o_writer_grant <= (w_nextState == WRITER);
            if (w_setTimeout) begin
                o_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        o_SPI_CS   = 1'b1;
        o_SPI_CLK  = 1'b0;
        o_SPI_MOSI = 1'b0;
        case (r_state)
            IDLE_CPU, HALT_WAIT: begin
                o_SPI_CS   = i_cpu_spi_cs;
                o_SPI_CLK  = i_cpu_spi_clk;
                o_SPI_MOSI = i_cpu_spi_mosi;
            end
            WRITER: begin
                o_SPI_CS   = i_wr_spi_cs;
                o_SPI_CLK  = i_wr_spi_clk;
                o_SPI_MOSI = i_wr_spi_mosi;
            end
            default: begin
                o_SPI_CS   = 1'b1;
                o_SPI_CLK  = 1'b0;
                o_SPI_MOSI = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: directed hand-over scenarios followed by a randomized run,
// every cycle compared against a behavioural model of bus ownership.
module tb_spi_bus_arbiter;

    localparam int SETTLE = 16;
    localparam int GUARD  = 4;
    localparam int DRAIN  = 64;

    localparam int S_IDLE     = 0;
    localparam int S_HALTWAIT = 1;
    localparam int S_GUARDIN  = 2;
    localparam int S_WRITER   = 3;
    localparam int S_GUARDOUT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_FT_CS;
    logic       i_cpu_spi_cs, i_cpu_spi_clk, i_cpu_spi_mosi;
    logic       i_wr_spi_cs, i_wr_spi_clk, i_wr_spi_mosi;
    logic       o_SPI_CS, o_SPI_CLK, o_SPI_MOSI;
    logic       o_HALT, o_cpu_grant, o_writer_grant, o_timeout;
    logic [2:0] o_state;

    int checks   = 0;
    int failures = 0;
    int edgeNum  = 0;
    bit randData = 1'b1;

    // Model: which phase of the hand-over we are in, how long we have been there,
    // the two synchronizer stages and the sticky timeout.
    int   mState;
    int   mCycles;
    logic mSync1, mSync2;
    logic mTimeout;

    always #5 clk = ~clk;

    spi_bus_arbiter #(
        .SETTLE_CYCLES(SETTLE),
        .GUARD_CYCLES (GUARD),
        .DRAIN_TIMEOUT(DRAIN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_FT_CS       (i_FT_CS),
        .i_cpu_spi_cs  (i_cpu_spi_cs),
        .i_cpu_spi_clk (i_cpu_spi_clk),
        .i_cpu_spi_mosi(i_cpu_spi_mosi),
        .i_wr_spi_cs   (i_wr_spi_cs),
        .i_wr_spi_clk  (i_wr_spi_clk),
        .i_wr_spi_mosi (i_wr_spi_mosi),
        .o_SPI_CS      (o_SPI_CS),
        .o_SPI_CLK     (o_SPI_CLK),
        .o_SPI_MOSI    (o_SPI_MOSI),
        .o_HALT        (o_HALT),
        .o_cpu_grant   (o_cpu_grant),
        .o_writer_grant(o_writer_grant),
        .o_timeout     (o_timeout),
        .o_state       (o_state)
    );

    task automatic checkEq(input string tag, input logic [2:0] observed, input logic [2:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d edge=%0d", tag, observed, expected, edgeNum);
        end
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic modelStep();
        int  nxt;
        bit  ftReq;
        if (!reset) begin
            mState   = S_IDLE;
            mCycles  = 0;
            mSync1   = 1'b1;
            mSync2   = 1'b1;
            mTimeout = 1'b0;
        end else begin
            ftReq = !mSync2;
            nxt   = mState;
            if (mState == S_IDLE) begin
                if (ftReq) nxt = S_HALTWAIT;
            end else if (mState == S_HALTWAIT) begin
                if (!ftReq) nxt = S_GUARDOUT;
                else if (mCycles + 1 >= SETTLE && i_cpu_spi_cs) nxt = S_GUARDIN;
                else if (mCycles + 1 == DRAIN) begin
                    nxt      = S_GUARDIN;
                    mTimeout = 1'b1;
                end
            end else if (mState == S_GUARDIN) begin
                if (!ftReq) nxt = S_GUARDOUT;
                else if (mCycles + 1 == GUARD) nxt = S_WRITER;
            end else if (mState == S_WRITER) begin
                if (!ftReq) nxt = S_GUARDOUT;
            end else begin
                if (mCycles + 1 == GUARD) nxt = S_IDLE;
            end
            mCycles = (nxt != mState) ? 0 : mCycles + 1;
            mState  = nxt;
            mSync2  = mSync1;
            mSync1  = i_FT_CS;
        end
    endtask

    task automatic checkOutput();
        logic expCs, expClk, expMosi;
        bit   cpuOwns;
        cpuOwns = (mState == S_IDLE) || (mState == S_HALTWAIT);
        if (cpuOwns) begin
            expCs = i_cpu_spi_cs; expClk = i_cpu_spi_clk; expMosi = i_cpu_spi_mosi;
        end else if (mState == S_WRITER) begin
            expCs = i_wr_spi_cs; expClk = i_wr_spi_clk; expMosi = i_wr_spi_mosi;
        end else begin
            expCs = 1'b1; expClk = 1'b0; expMosi = 1'b0;
        end
        checkEq("state",        o_state,                3'(mState));
        checkEq("halt",         3'(o_HALT),             3'(mState == S_IDLE));
        checkEq("cpu_grant",    3'(o_cpu_grant),        3'(cpuOwns));
        checkEq("writer_grant", 3'(o_writer_grant),     3'(mState == S_WRITER));
        checkEq("timeout",      3'(o_timeout),          3'(mTimeout));
        checkEq("spi_bus",      {o_SPI_CS, o_SPI_CLK, o_SPI_MOSI}, {expCs, expClk, expMosi});
    endtask

    // Run n clock edges, scrambling the SPI data lines before each when enabled.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            if (randData) begin
                i_cpu_spi_clk  = 1'($urandom);
                i_cpu_spi_mosi = 1'($urandom);
                i_wr_spi_cs    = 1'($urandom);
                i_wr_spi_clk   = 1'($urandom);
                i_wr_spi_mosi  = 1'($urandom);
                #1;
                checkEq("spi_comb", {o_SPI_CS, o_SPI_CLK, o_SPI_MOSI},
                        (mState == S_WRITER) ? {i_wr_spi_cs, i_wr_spi_clk, i_wr_spi_mosi} :
                        (mState <= S_HALTWAIT) ? {i_cpu_spi_cs, i_cpu_spi_clk, i_cpu_spi_mosi} : 3'b100);
            end
            @(posedge clk);
            modelStep();
            edgeNum++;
            #1;
            checkOutput();
        end
    endtask

    task automatic resetDut();
        reset        = 1'b0;
        i_FT_CS      = 1'b1;
        i_cpu_spi_cs = 1'b1;
        applyStimulus(2);
        checkEq("rst_state",  o_state,            3'd0);
        checkEq("rst_halt",   3'(o_HALT),         3'd1);
        checkEq("rst_cpu",    3'(o_cpu_grant),    3'd1);
        checkEq("rst_writer", 3'(o_writer_grant), 3'd0);
        checkEq("rst_tmo",    3'(o_timeout),      3'd0);
    endtask

    initial begin
        reset          = 1'b0;
        i_FT_CS        = 1'b1;
        i_cpu_spi_cs   = 1'b1;
        i_cpu_spi_clk  = 1'b0;
        i_cpu_spi_mosi = 1'b0;
        i_wr_spi_cs    = 1'b1;
        i_wr_spi_clk   = 1'b0;
        i_wr_spi_mosi  = 1'b0;
        mState = S_IDLE; mCycles = 0; mSync1 = 1'b1; mSync2 = 1'b1; mTimeout = 1'b0;

        // Clean hand-over with the CPU idle: halt at 3, guard at 19, writer at 23.
        resetDut();
        reset = 1'b1; i_FT_CS = 1'b0; edgeNum = 0;
        applyStimulus(2);
        checkEq("req31_halt_e2", 3'(o_HALT), 3'd1);
        applyStimulus(1);
        checkEq("req31_halt_e3", 3'(o_HALT), 3'd0);
        applyStimulus(15);
        checkEq("req31_state_e18", o_state, 3'd1);
        applyStimulus(1);
        checkEq("req31_state_e19", o_state, 3'd2);
        applyStimulus(3);
        checkEq("req31_wgrant_e22", 3'(o_writer_grant), 3'd0);
        applyStimulus(1);
        checkEq("req31_wgrant_e23", 3'(o_writer_grant), 3'd1);

        // Writer releases: guard out three edges later, bus idle for exactly GUARD cycles.
        applyStimulus(5);
        i_FT_CS = 1'b1;
        applyStimulus(2);
        checkEq("req34_still_writer", o_state, 3'd3);
        for (int i = 0; i < GUARD; i++) begin
            applyStimulus(1);
            checkEq("req34_guard_state", o_state, 3'd4);
            checkEq("req34_guard_cs", 3'(o_SPI_CS), 3'd1);
        end
        applyStimulus(1);
        checkEq("req34_idle_state", o_state, 3'd0);
        checkEq("req34_idle_halt", 3'(o_HALT), 3'd1);
        checkEq("req34_cpu_pass", 3'(o_SPI_CS), 3'(i_cpu_spi_cs));

        // CPU busy until edge 30: HALT_WAIT stretched, no timeout.
        resetDut();
        reset = 1'b1; i_FT_CS = 1'b0; i_cpu_spi_cs = 1'b0; edgeNum = 0;
        applyStimulus(30);
        checkEq("req32_state_e30", o_state, 3'd1);
        i_cpu_spi_cs = 1'b1;
        applyStimulus(1);
        checkEq("req32_state_e31", o_state, 3'd2);
        checkEq("req32_timeout", 3'(o_timeout), 3'd0);
        applyStimulus(6);
        i_FT_CS = 1'b1;
        applyStimulus(10);

        // CPU never releases: forced hand-over at edge 67, timeout sticks.
        resetDut();
        reset = 1'b1; i_FT_CS = 1'b0; i_cpu_spi_cs = 1'b0; edgeNum = 0;
        applyStimulus(66);
        checkEq("req33_state_e66", o_state, 3'd1);
        checkEq("req33_tmo_e66", 3'(o_timeout), 3'd0);
        applyStimulus(1);
        checkEq("req33_state_e67", o_state, 3'd2);
        checkEq("req33_tmo_e67", 3'(o_timeout), 3'd1);
        applyStimulus(6);
        i_FT_CS = 1'b1;
        applyStimulus(12);
        checkEq("req33_back_idle", o_state, 3'd0);
        checkEq("req33_tmo_sticky", 3'(o_timeout), 3'd1);

        // Short request pulse: abort from HALT_WAIT, writer never granted.
        resetDut();
        reset = 1'b1; i_FT_CS = 1'b0; i_cpu_spi_cs = 1'b1; edgeNum = 0;
        applyStimulus(5);
        i_FT_CS = 1'b1;
        applyStimulus(3);
        checkEq("req35_abort_e8", o_state, 3'd4);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1);
            checkEq("req35_no_wgrant", 3'(o_writer_grant), 3'd0);
        end
        checkEq("req35_idle", o_state, 3'd0);

        // Random traffic: request toggles, CPU busy bias changes, occasional reset.
        for (int blk = 0; blk < 6; blk++) begin
            int csOnePct;
            csOnePct = (blk % 2 == 0) ? 30 : 2;
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 59) == 0) i_FT_CS = ~i_FT_CS;
                i_cpu_spi_cs = ($urandom_range(0, 99) < csOnePct);
                reset = ($urandom_range(0, 399) != 0);
                applyStimulus(1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_bus_arbiter.md
SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16, minimum cycles o_HALT is held low before the CPU path may be cut off.
REQ-002 Parameter GUARD_CYCLES, default 4, cycles the flash bus is held idle on each hand-over.
REQ-003 Parameter DRAIN_TIMEOUT, default 64, maximum cycles in HALT_WAIT before a forced hand-over; all parameters SHALL be 1..255.
REQ-004 clk  input  1  OSCH internal clock, 44.33 MHz; all logic on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 i_FT_CS  input  1  FT2232 chip select, asynchronous to clk; low = programming requested.
REQ-007 i_cpu_spi_cs, i_cpu_spi_clk, i_cpu_spi_mosi  input  1 each  SPI signals from the 6809 flash read controller.
REQ-008 i_wr_spi_cs, i_wr_spi_clk, i_wr_spi_mosi  input  1 each  SPI signals from the flash writer.
REQ-009 o_SPI_CS, o_SPI_CLK, o_SPI_MOSI  output  1 each  signals to the flash device.
REQ-010 o_HALT  output  1  6809 HALT, active low.
REQ-011 o_cpu_grant, o_writer_grant  output  1 each  current bus owner, one-hot or both 0.
REQ-012 o_timeout  output  1  sticky flag, set by a forced hand-over.
REQ-013 o_state  output  3  state code: IDLE_CPU=0, HALT_WAIT=1, GUARD_IN=2, WRITER=3, GUARD_OUT=4.

Function
REQ-014 i_FT_CS SHALL pass through a 2-flop synchronizer; ft_req = inverted second-stage output.
REQ-015 One 8-bit cycle counter SHALL clear on every state entry and increment each cycle while in a state.
REQ-016 IDLE_CPU: CPU signals pass to the flash; o_HALT=1; o_cpu_grant=1. Go to HALT_WAIT when ft_req=1.
REQ-017 HALT_WAIT: CPU signals still pass; o_HALT=0; o_cpu_grant=1.
REQ-018 HALT_WAIT exit to GUARD_IN when counter>=SETTLE_CYCLES-1 and i_cpu_spi_cs=1.
REQ-019 HALT_WAIT forced exit to GUARD_IN when counter=DRAIN_TIMEOUT-1 regardless of i_cpu_spi_cs; o_timeout set to 1.
REQ-020 GUARD_IN: flash forced idle (CS=1, CLK=0, MOSI=0); o_HALT=0; both grants 0. Go to WRITER after GUARD_CYCLES cycles.
REQ-021 WRITER: writer signals pass to the flash; o_HALT=0; o_writer_grant=1. Go to GUARD_OUT when ft_req=0.
REQ-022 GUARD_OUT: flash forced idle; o_HALT=0; both grants 0. Go to IDLE_CPU after GUARD_CYCLES cycles.
REQ-023 ft_req=0 in HALT_WAIT or GUARD_IN SHALL abort to GUARD_OUT; abort takes priority over the REQ-018/019/020 exits.
REQ-024 ft_req=1 during GUARD_OUT SHALL NOT shorten the guard; IDLE_CPU is entered, then HALT_WAIT on the next cycle.
REQ-025 o_HALT, grants, o_state and o_timeout SHALL be registered; SPI outputs SHALL be combinational from registered state plus the selected inputs only.
REQ-026 The flash SHALL never see a cycle with both requesters' signals mixed; any owner change passes through a forced-idle state of >=GUARD_CYCLES cycles.
REQ-027 o_timeout SHALL clear only on reset.
REQ-028 Unused state codes 5-7 SHALL return to GUARD_OUT on the next cycle.

Reset
REQ-029 With reset=0 at a clock edge: state=IDLE_CPU, counter=0, synchronizer flops=1 (no request), o_HALT=1, o_cpu_grant=1, o_writer_grant=0, o_timeout=0, o_state=0.
REQ-030 Reset during WRITER SHALL return to IDLE_CPU immediately with no guard; the writer is responsible for re-requesting.

Verification
REQ-031 Reset, cpu_cs=1, i_FT_CS 1->0 before edge 1 -> o_HALT=0 at edge 3, o_state=2 at edge 19, o_writer_grant=1 at edge 23.
REQ-032 As REQ-031 but i_cpu_spi_cs=0 until edge 30 -> HALT_WAIT is held past SETTLE, GUARD_IN is entered at edge 31, o_timeout=0.
REQ-033 i_cpu_spi_cs held 0 permanently -> GUARD_IN at counter 63 (edge 67), o_timeout=1 and remains 1 after return to IDLE_CPU.
REQ-034 In WRITER, i_FT_CS->1 -> GUARD_OUT 3 edges later, flash CS=1 for exactly 4 cycles, then o_HALT=1 and CPU pass-through.
REQ-035 i_FT_CS pulses low for 5 cycles only -> HALT_WAIT aborts to GUARD_OUT, writer is never granted, IDLE_CPU is reached.
REQ-036 Toggle writer and CPU inputs randomly in every state -> flash outputs always equal the owner's signals or the idle value, never a mix.
